// File: rtl/instr_entry_issuer_pkg.sv
// instr_entry_issuer_pkg: opcode, field-width and entry-stage definitions shared with the execute unit
package instr_entry_issuer_pkg;
  localparam int SEL_W = 3;
  localparam int REG_W = 4;
  localparam int INSTR_W = SEL_W + 2 * REG_W;
  localparam logic [SEL_W-1:0] OP_SUB = 3'd0;
  localparam logic [SEL_W-1:0] OP_ADD = 3'd1;
  localparam logic [SEL_W-1:0] OP_OR = 3'd2;
  localparam logic [SEL_W-1:0] OP_AND = 3'd3;
  localparam logic [SEL_W-1:0] OP_RSHIFT = 3'd4;
  localparam logic [SEL_W-1:0] OP_LSHIFT = 3'd5;
  localparam logic [SEL_W-1:0] OP_LT = 3'd6;
  localparam logic [SEL_W-1:0] OP_EQ = 3'd7;
  typedef enum logic [1:0] {S_RS = 2'd0, S_RT = 2'd1, S_OP = 2'd2, S_ISSUE = 2'd3} state_t;
endpackage

// File: rtl/instr_entry_issuer_btn.sv
// btn_debounce_pulse: 2-flop synchroniser, stable-sample debounce and rising-edge one-pulse for a raw button
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic filt, filt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      filt <= 1'b0;
      filt_d <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      filt_d <= filt;
      if (sync[1] == filt) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign pulse = filt & ~filt_d;
endmodule

// File: rtl/instr_entry_issuer.sv
// instr_entry_issuer: switch/ENTER entry of {sel, rs, rt} issued over valid/ready.
// Define ISSUE_FIFO_EN to queue up to FIFO_DEPTH instructions instead of holding a single one.
module instr_entry_issuer
  import instr_entry_issuer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] sw_val,
  input  logic [SEL_W-1:0] sw_op,
  input  logic             btn_enter,
  input  logic             btn_cancel,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [SEL_W-1:0] issue_sel,
  output logic [REG_W-1:0] issue_rs,
  output logic [REG_W-1:0] issue_rt,
  output logic [1:0]       stage,
  output logic             busy
);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  logic [1:0] rst_sync;
  logic rst_i_n, enter_p, cancel_p;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];
  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .rst_n(rst_i_n), .btn(btn_enter), .pulse(enter_p)
  );
  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk(clk), .rst_n(rst_i_n), .btn(btn_cancel), .pulse(cancel_p)
  );
  state_t state, state_d;
  logic [REG_W-1:0] rs_q, rt_q, rs_d, rt_d;
`ifdef ISSUE_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [INSTR_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, can_push;
  assign issue_valid = count != '0;
  assign pop = issue_valid & issue_ready;
  // a pop in the same cycle frees the slot a full-queue push needs
  assign can_push = count != (AW + 1)'(FIFO_DEPTH) || pop;
`else
  logic [SEL_W-1:0] sel_q, sel_d;
  assign issue_valid = state == S_ISSUE;
`endif
  always_comb begin
    state_d = state;
    rs_d = rs_q;
    rt_d = rt_q;
`ifdef ISSUE_FIFO_EN
    push = 1'b0;
`else
    sel_d = sel_q;
`endif
    case (state)
      S_RS: if (enter_p) begin
        rs_d = sw_val;
        state_d = S_RT;
      end
      S_RT: if (enter_p) begin
        rt_d = sw_val;
        state_d = S_OP;
      end
`ifdef ISSUE_FIFO_EN
      S_OP: if (enter_p && can_push) begin
        push = 1'b1;
        state_d = S_RS;
      end
      default: state_d = S_RS;
`else
      S_OP: if (enter_p) begin
        sel_d = sw_op;
        state_d = S_ISSUE;
      end
      default: if (issue_ready) state_d = S_RS;
`endif
    endcase
    // cancel beats a coincident enter but never withdraws an asserted valid
    if (cancel_p && state != S_ISSUE) begin
      state_d = S_RS;
      rs_d = '0;
      rt_d = '0;
`ifdef ISSUE_FIFO_EN
      push = 1'b0;
`else
      sel_d = '0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state <= S_RS;
      rs_q <= '0;
      rt_q <= '0;
`ifndef ISSUE_FIFO_EN
      sel_q <= '0;
`endif
    end else begin
      state <= state_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
`ifndef ISSUE_FIFO_EN
      sel_q <= sel_d;
`endif
    end
  end
`ifdef ISSUE_FIFO_EN
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sw_op, rs_q, rt_q};
  end
  assign {issue_sel, issue_rs, issue_rt} = issue_valid ? mem[rd_ptr] : '0;
`else
  assign {issue_sel, issue_rs, issue_rt} = issue_valid ? {sel_q, rs_q, rt_q} : '0;
`endif
  assign busy = issue_valid;
  assign stage = state;
endmodule
